// File: rtl/fec_pkg.sv
// Shared types and defaults for the FEC block's UART transmit arbiter.
//
// Contents:
//   uart_arb_state_t   arbiter state encoding (IDLE, HOLD, GAP)
//   UART_ARB_NREQ      default number of requesters
//   UART_ARB_HOLD_MAX  default watchdog limit, in cycles
package fec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } uart_arb_state_t;

    localparam int UART_ARB_NREQ     = 2;
    localparam int UART_ARB_HOLD_MAX = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//
// Ports:
//   req     in   NREQ  request vector
//   ptr     in   PW    index of the last winner; the search starts at ptr+1
//   winner  out  NREQ  one-hot winner (0 when no request)
//   valid   out  1     at least one request is set
module rr_pick #(
    parameter int NREQ = 2,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    // First pass looks above ptr, second pass wraps around to index 0.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (PW'(i) > ptr)) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i]) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-locked round-robin arbiter for the single UART TX FIFO write port.
// Requester 0 is the FEC control FSM, requester 1 the uplink FEC engine.
// The holder keeps the grant until it drops req; writes from the holder pass
// straight through to the FIFO, gated by fifo_full.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to build the hold watchdog.
//
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   req[NREQ]     per-requester frame request (level)
//   wr[NREQ]      per-requester write strobe
//   wdata         per-requester write data [NREQ-1:0][MDW-1:0]
//   grant[NREQ]   registered one-hot grant
//   fifo_wr       write strobe to UART TX FIFO
//   fifo_wdata    write data to UART TX FIFO
//   fifo_full     UART TX FIFO full
//   accept[NREQ]  combinational write-accepted indication
//   busy          state is not IDLE
//   viol_flag     sticky: write without grant
//   ovf_flag      sticky: granted write while FIFO full
//   timeout_flag  sticky: watchdog forced a release (0 without the watchdog)
//   flag_clear    synchronous clear of the sticky flags
//
// state | meaning
// IDLE  | no grant, pick a winner when any req is set
// HOLD  | grant held by the winner until its req drops (or watchdog fires)
// GAP   | one dead cycle with grant = 0 before the next arbitration
module uart_tx_arb
    import fec_pkg::*;
#(
    parameter int NREQ     = UART_ARB_NREQ,
    parameter int MDW      = 8,
    parameter int FAW      = 4,
    parameter int HOLD_MAX = UART_ARB_HOLD_MAX
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           wr,
    input  logic [NREQ-1:0][MDW-1:0]  wdata,
    output logic [NREQ-1:0]           grant,
    output logic                      fifo_wr,
    output logic [MDW-1:0]            fifo_wdata,
    input  logic                      fifo_full,
    output logic [NREQ-1:0]           accept,
    output logic                      busy,
    output logic                      viol_flag,
    output logic                      ovf_flag,
    output logic                      timeout_flag,
    input  logic                      flag_clear
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 4 || FAW < 1 || HOLD_MAX < 2) begin : g_bad_cfg
        $error("uart_tx_arb: unsupported parameter set");
    end

    uart_arb_state_t state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] pick_winner;
    logic            pick_valid;
    logic [PW-1:0]   grant_idx;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) grant_idx = PW'(i);
        end
    end

    // Write path: zero latency from wr / fifo_full.
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign accept  = grant_q & {NREQ{~fifo_full}};
    assign fifo_wr = (|(wr & grant_q)) & ~fifo_full;

    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) fifo_wdata = fifo_wdata | wdata[i];
        end
    end

    logic viol_set, ovf_set;
    assign viol_set = |(wr & ~grant_q);
    assign ovf_set  = (|(wr & grant_q)) & fifo_full;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold_cnt;
    logic          hold_expired;
    logic          timeout_set;

    // Fires in the HOLD_MAX-th consecutive HOLD cycle without an accepted
    // write, so the release lands on the following edge.
    assign hold_expired = (state_q == HOLD) && !fifo_wr &&
                          (hold_cnt >= CW'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_q != HOLD || fifo_wr) begin
            hold_cnt <= '0;
        end else if (hold_cnt != CW'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_flag <= 1'b0;
        else        timeout_flag <= timeout_set | (timeout_flag & ~flag_clear);
    end
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = HOLD;
                    grant_d = pick_winner;
                end
            end
            HOLD: begin
                if ((req & grant_q) == '0) begin
                    state_d = GAP;
                    grant_d = '0;
                    ptr_d   = grant_idx;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (hold_expired) begin
                    state_d     = GAP;
                    grant_d     = '0;
                    ptr_d       = grant_idx;
                    timeout_set = 1'b1;
                end
`endif
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PW'(NREQ - 1);
            viol_flag <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            // Set beats a simultaneous clear.
            viol_flag <= viol_set | (viol_flag & ~flag_clear);
            ovf_flag  <= ovf_set  | (ovf_flag  & ~flag_clear);
        end
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

- Shares the single UART transmit FIFO write port between frame-producing requesters:
  - requester 0 is the FEC control FSM (downlink echo/status path);
  - requester 1 is the uplink FEC engine.
- Grants are round-robin and frame-locked: the holder keeps the grant until it drops `req`.
- Writes from the granted requester pass through to the UART TX FIFO with full-gating.
- Protocol violations raise sticky flags for register readback; an optional hold watchdog reclaims the grant from a stalled holder.
- Sits between the requesters and `EF_UART` `wr`/`wdata`, replacing its internal req/grant pair.

## Interface
- `NREQ`, 2, number of requesters (2..4).
- `MDW`, 8, UART data width.
- `FAW`, 4, TX FIFO address width; level range 0..2**FAW-1.
- `HOLD_MAX`, 64, watchdog limit in cycles of held grant with no accepted write (≥2).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester frame request; level, held for the whole frame.
- `wr`  in  NREQ  per-requester write strobe, one byte per cycle.
- `wdata`  in  NREQ×MDW  per-requester write data, packed `[NREQ-1:0][MDW-1:0]`.
- `grant`  out  NREQ  one-hot grant, registered.
- `fifo_wr`  out  1  write strobe to UART TX FIFO.
- `fifo_wdata`  out  MDW  data to UART TX FIFO.
- `fifo_full`  in  1  UART TX FIFO full.
- `accept`  out  NREQ  per-requester write-accepted indication, combinational.
- `busy`  out  1  a grant is held or a gap cycle is in progress.
- `viol_flag`  out  1  sticky: a write was seen without grant.
- `ovf_flag`  out  1  sticky: a write was attempted while `fifo_full`.
- `timeout_flag`  out  1  sticky: the watchdog forced a release.
- `flag_clear`  in  1  synchronous clear of all three sticky flags.

## Operation
- State machine `IDLE`, `HOLD`, `GAP`:
  - `IDLE`: if `req`≠0, pick a winner and go to `HOLD`. Otherwise stay in `IDLE`.
  - `HOLD`: `grant` is one-hot for the winner.
    - If `req[winner]`=0, go to `GAP` and update the pointer to the winner.
    - Under `UART_ARB_TIMEOUT_EN`, if the hold counter reaches `HOLD_MAX`, force `GAP` and set `timeout_flag`.
  - `GAP`: one cycle with `grant`=0, then return to `IDLE`.
- Round-robin pick:
  - Search starts at index `ptr+1` mod `NREQ`.
  - Winner = first set `req` bit.
  - `ptr` resets to `NREQ-1`, so `req0` wins first.
- Write path:
  - `fifo_wr` = `wr[g]` & `grant[g]` & ~`fifo_full`.
  - `fifo_wdata` = `wdata[g]` when `grant[g]`, else 0.
  - `accept[i]` = `grant[i]` & ~`fifo_full`.
  - Requesters retry any byte until `accept` is high.
- Flags:
  - `wr[i]` while `grant[i]`=0 → byte dropped, `viol_flag` set.
  - `wr[g]` while `fifo_full` → byte not written, `ovf_flag` set.
  - If a flag's set condition and `flag_clear` occur in the same cycle, set wins.
- Hold counter:
  - Resets to 0 on entry to `HOLD` and on every accepted write.
  - Otherwise increments, saturating at `HOLD_MAX`.
- Reset mid-frame: all state returns to reset values immediately. A requester must re-raise `req`.

## Timing
- Reset values:
  - `grant`=0, `fifo_wr`=0, `fifo_wdata`=0, `accept`=0, `busy`=0.
  - All flags = 0.
  - State = `IDLE`, `ptr`=`NREQ-1`, counter = 0.
- `req` rising in cycle N while `IDLE` → `grant` high in N+1.
- First write may be accepted in N+1, in the same cycle as `grant`.
- `req[g]` low in cycle M → `grant` low in M+1 (`GAP`). The next grant is earliest at M+3.
- The write path has zero latency (combinational from `wr`/`fifo_full`). `grant` and the flags are registered.
- A `req` drop in the same cycle as a last write: the write is accepted, then release follows.
- Watchdog: with no accepted write for `HOLD_MAX` consecutive cycles in `HOLD` → `GAP` on the next edge. `timeout_flag` is set on that edge.
- `busy` = state≠`IDLE`.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- Defined: hold counter and watchdog are present; `timeout_flag` behaves as above.
- Undefined:
  - No counter is built.
  - The grant is held until `req` drops, with no upper bound.
  - `timeout_flag` is tied 0.

## Structure
- `fec_pkg` holds:
  - `uart_arb_state_t` enum (`IDLE`, `HOLD`, `GAP`);
  - `UART_ARB_NREQ` = 2;
  - `UART_ARB_HOLD_MAX` = 64.
- One sub-module, `rr_pick`:
  - combinational round-robin selector;
  - inputs `req` and `ptr`;
  - outputs one-hot `winner` and `valid`;
  - parameterised by `NREQ`.

## Test plan
- Reset, then `req`=2'b11 at cycle 10:
  - `grant`=2'b01 at cycle 11;
  - `req0` drops at 20 → `grant`=0 at 21;
  - `grant`=2'b10 at 23.
- `grant0` held, `wr0` bursts 0xA5,0x5A with `fifo_full`=0 → `fifo_wr` two cycles, data 0xA5 then 0x5A, `accept0`=1.
- `fifo_full`=1 during `wr0` of 0x3C → `fifo_wr`=0, `ovf_flag`=1 next cycle. `flag_clear` pulse → 0.
- `wr1`=1 with 0x77 while `grant`=2'b01 → `fifo_wr`=0, `viol_flag`=1.
- `UART_ARB_TIMEOUT_EN`, `HOLD_MAX`=8: `req0` held, no writes → `grant` low after 8 idle `HOLD` cycles, `timeout_flag`=1, `req1` granted 2 cycles later.
- `rst_n` asserted mid-frame while `grant`=2'b10 → `grant`=0, `busy`=0 immediately. After release, `req`=2'b11 → `grant`=2'b01 first.
